eb_slave_core: RTL and testbench

//  Ethernet-to-Wishbone bridge (remote-slave mode). Receives a command frame on a 16-bit

---
 rtl/eb_slave_core.sv | 216 +++++++++++++++++++++
 tb/tb_eb_slave_core.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eb_slave_core.sv
// rtl/eb_slave_core.sv - Ethernet-to-Wishbone remote-slave bridge core
//
// Takes one command frame from a 16-bit pipelined WB fabric sink, performs a
// single 32-bit access on the WB master port, then returns a fixed 30-word
// reply frame on the 16-bit WB fabric source.
//
// Ports:
//   clk_i, nRst_i                     clock; synchronous active-low reset
//   snk_cyc_i/stb_i/we_i/dat_i/adr_i/sel_i, snk_stall_o, snk_ack_o
//                                     command frame in (fabric sink)
//   src_cyc_o/stb_o/we_o/dat_o/adr_o/sel_o, src_ack_i, src_stall_i
//                                     reply frame out (fabric source)
//   master_cyc_o/we_o/stb_o/sel_o/adr_o/dat_o, master_dat_i,
//   master_ack_i, master_stall_i      local bus master port
module eb_slave_core #(
    parameter int          g_master_slave = 0,
    parameter logic [47:0] g_mac          = 48'h000000000000,
    parameter int          g_timeout      = 255
) (
    input  logic        clk_i,
    input  logic        nRst_i,
    input  logic        snk_cyc_i,
    input  logic        snk_stb_i,
    input  logic        snk_we_i,
    input  logic [15:0] snk_dat_i,
    input  logic [1:0]  snk_adr_i,
    input  logic [1:0]  snk_sel_i,
    output logic        snk_stall_o,
    output logic        snk_ack_o,
    output logic        src_cyc_o,
    output logic        src_stb_o,
    output logic        src_we_o,
    output logic [15:0] src_dat_o,
    output logic [1:0]  src_adr_o,
    output logic [1:0]  src_sel_o,
    input  logic        src_ack_i,
    input  logic        src_stall_i,
    output logic        master_cyc_o,
    output logic        master_we_o,
    output logic        master_stb_o,
    output logic [3:0]  master_sel_o,
    output logic [31:0] master_adr_o,
    output logic [31:0] master_dat_o,
    input  logic [31:0] master_dat_i,
    input  logic        master_ack_i,
    input  logic        master_stall_i
);

    // Only the remote-slave mode exists; any other value builds the same core.
    generate
        if (g_master_slave != 0) begin : g_mode_fallback
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX,
        S_BUS_REQ,
        S_BUS_WAIT,
        S_TX
    } state_t;

    // Data word 11 carries the last write-data half; 12 words means a complete command.
    localparam logic [3:0]  RX_FULL  = 4'd12;
    localparam logic [4:0]  TX_LAST  = 5'd29;
    localparam int unsigned TMO_LAST = (g_timeout > 1) ? g_timeout - 1 : 0;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  rx_cnt;
    logic [4:0]  tx_cnt;
    logic [31:0] tmo_cnt;
    logic [47:0] req_src;
    logic [15:0] req_etype;
    logic        req_we;
    logic [3:0]  req_sel;
    logic [31:0] req_adr;
    logic [31:0] req_dat;
    logic [1:0]  rsp_status;
    logic [31:0] rsp_data;

    logic sink_xfer;
    logic data_xfer;
    logic bus_busy;
    logic bus_tmo;

    logic unused_inputs;
    assign unused_inputs = &{1'b0, src_ack_i, snk_we_i, snk_sel_i};

    // The sink never stalls in IDLE/RX, so any strobe there is a transfer.
    assign sink_xfer = (state == S_IDLE || state == S_RX) && snk_cyc_i && snk_stb_i;
    assign data_xfer = sink_xfer && (snk_adr_i == 2'b00);
    assign bus_busy  = (state == S_BUS_REQ) || (state == S_BUS_WAIT);
    assign bus_tmo   = (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk_i) begin
        if (!nRst_i) begin
            state      <= S_IDLE;
            snk_ack_o  <= 1'b0;
            rx_cnt     <= 4'd0;
            tx_cnt     <= 5'd0;
            tmo_cnt    <= 32'd0;
            req_src    <= 48'd0;
            req_etype  <= 16'd0;
            req_we     <= 1'b0;
            req_sel    <= 4'd0;
            req_adr    <= 32'd0;
            req_dat    <= 32'd0;
            rsp_status <= 2'b00;
            rsp_data   <= 32'd0;
        end else begin
            state     <= state_nxt;
            snk_ack_o <= sink_xfer;

            // Word index counts data words only; it saturates so long frames are harmless.
            if (data_xfer && rx_cnt != RX_FULL) begin
                rx_cnt <= rx_cnt + 4'd1;
                case (rx_cnt)
                    4'd3:  req_src[47:32]  <= snk_dat_i;
                    4'd4:  req_src[31:16]  <= snk_dat_i;
                    4'd5:  req_src[15:0]   <= snk_dat_i;
                    4'd6:  req_etype       <= snk_dat_i;
                    4'd7: begin
                        req_we  <= snk_dat_i[4];
                        req_sel <= snk_dat_i[3:0];
                    end
                    4'd8:  req_adr[31:16]  <= snk_dat_i;
                    4'd9:  req_adr[15:0]   <= snk_dat_i;
                    4'd10: req_dat[31:16]  <= snk_dat_i;
                    4'd11: req_dat[15:0]   <= snk_dat_i;
                    default: ;
                endcase
            end else if (state == S_RX && !snk_cyc_i) begin
                rx_cnt <= 4'd0;
            end

            tmo_cnt <= bus_busy ? tmo_cnt + 32'd1 : 32'd0;

            if (bus_busy) begin
                if (master_ack_i) begin
                    rsp_status <= 2'b01;
                    rsp_data   <= req_we ? 32'd0 : master_dat_i;
                end else if (bus_tmo) begin
                    rsp_status <= 2'b10;
                    rsp_data   <= 32'd0;
                end
            end

            if (state != S_TX) begin
                tx_cnt <= 5'd0;
            end else if (!src_stall_i) begin
                tx_cnt <= tx_cnt + 5'd1;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        snk_stall_o  = 1'b1;
        master_cyc_o = 1'b0;
        master_stb_o = 1'b0;
        src_cyc_o    = 1'b0;
        src_stb_o    = 1'b0;
        src_we_o     = 1'b0;
        src_sel_o    = 2'b00;
        src_adr_o    = 2'b00;
        src_dat_o    = 16'd0;
        master_we_o  = req_we;
        master_sel_o = req_sel;
        master_adr_o = req_adr;
        master_dat_o = req_dat;

        case (state)
            S_IDLE: begin
                snk_stall_o = 1'b0;
                if (snk_cyc_i) state_nxt = S_RX;
            end
            S_RX: begin
                snk_stall_o = 1'b0;
                if (!snk_cyc_i) state_nxt = (rx_cnt == RX_FULL) ? S_BUS_REQ : S_IDLE;
            end
            S_BUS_REQ: begin
                master_cyc_o = 1'b1;
                master_stb_o = 1'b1;
                if (master_ack_i || bus_tmo) state_nxt = S_TX;
                else if (!master_stall_i)    state_nxt = S_BUS_WAIT;
            end
            S_BUS_WAIT: begin
                master_cyc_o = 1'b1;
                if (master_ack_i || bus_tmo) state_nxt = S_TX;
            end
            S_TX: begin
                src_cyc_o = 1'b1;
                src_stb_o = 1'b1;
                src_we_o  = 1'b1;
                src_sel_o = 2'b11;
                case (tx_cnt)
                    5'd0: src_dat_o = req_src[47:32];
                    5'd1: src_dat_o = req_src[31:16];
                    5'd2: src_dat_o = req_src[15:0];
                    5'd3: src_dat_o = g_mac[47:32];
                    5'd4: src_dat_o = g_mac[31:16];
                    5'd5: src_dat_o = g_mac[15:0];
                    5'd6: src_dat_o = req_etype;
                    5'd7: src_dat_o = {14'd0, rsp_status};
                    5'd8: src_dat_o = rsp_data[31:16];
                    5'd9: src_dat_o = rsp_data[15:0];
                    default: src_dat_o = 16'd0;
                endcase
                if (!src_stall_i && tx_cnt == TX_LAST) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_eb_slave_core.sv
// tb/tb_eb_slave_core.sv - scoreboard bench for eb_slave_core
module tb_eb_slave_core;

    localparam int          TMO = 40;
    localparam logic [47:0] MAC = 48'h02ABCDEF0123;

    logic        clk_i = 1'b0;
    logic        nRst_i;
    logic        snk_cyc_i, snk_stb_i, snk_we_i;
    logic [15:0] snk_dat_i;
    logic [1:0]  snk_adr_i, snk_sel_i;
    logic        snk_stall_o, snk_ack_o;
    logic        src_cyc_o, src_stb_o, src_we_o;
    logic [15:0] src_dat_o;
    logic [1:0]  src_adr_o, src_sel_o;
    logic        src_ack_i;
    logic        src_stall_i = 1'b0;
    logic        master_cyc_o, master_we_o, master_stb_o;
    logic [3:0]  master_sel_o;
    logic [31:0] master_adr_o, master_dat_o;
    logic [31:0] master_dat_i = 32'd0;
    logic        master_ack_i = 1'b0;
    logic        master_stall_i = 1'b0;

    eb_slave_core #(.g_master_slave(0), .g_mac(MAC), .g_timeout(TMO)) dut (
        .clk_i(clk_i), .nRst_i(nRst_i),
        .snk_cyc_i(snk_cyc_i), .snk_stb_i(snk_stb_i), .snk_we_i(snk_we_i),
        .snk_dat_i(snk_dat_i), .snk_adr_i(snk_adr_i), .snk_sel_i(snk_sel_i),
        .snk_stall_o(snk_stall_o), .snk_ack_o(snk_ack_o),
        .src_cyc_o(src_cyc_o), .src_stb_o(src_stb_o), .src_we_o(src_we_o),
        .src_dat_o(src_dat_o), .src_adr_o(src_adr_o), .src_sel_o(src_sel_o),
        .src_ack_i(src_ack_i), .src_stall_i(src_stall_i),
        .master_cyc_o(master_cyc_o), .master_we_o(master_we_o), .master_stb_o(master_stb_o),
        .master_sel_o(master_sel_o), .master_adr_o(master_adr_o), .master_dat_o(master_dat_o),
        .master_dat_i(master_dat_i), .master_ack_i(master_ack_i), .master_stall_i(master_stall_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
    } mst_t;

    typedef struct packed {
        logic [47:0] dst;
        logic [15:0] et;
        logic [1:0]  st;
        logic [31:0] rd;
    } rpl_t;

    int          n_cmp = 0;
    int          n_err = 0;
    mst_t        mst_obs[$];
    mst_t        mst_exp_q[$];
    rpl_t        rpl_exp_q[$];
    logic [15:0] rpl_q[$];
    logic [31:0] slave_mem[int];
    logic [31:0] exp_mem[int];
    int          ack_cnt, xfers, bad_attr, cyc_run, cyc_len, src_stall_left;
    bit          ack_en, mst_stall_en, src_stall_en, throttle_en;
    logic [47:0] cur_src;
    logic [15:0] cur_et;

    // Local-bus slave: one-cycle ack, byte-lane writes, random stall.
    always @(posedge clk_i) begin
        master_ack_i   <= 1'b0;
        master_stall_i <= mst_stall_en && ($urandom_range(9, 0) == 0);
        if (nRst_i && master_cyc_o && master_stb_o && !master_stall_i) begin
            mst_obs.push_back({master_we_o, master_sel_o, master_adr_o, master_dat_o});
            if (ack_en) begin
                logic [31:0] m;
                int          a;
                a = int'(master_adr_o);
                m = slave_mem.exists(a) ? slave_mem[a] : 32'd0;
                master_ack_i <= 1'b1;
                master_dat_i <= m;
                if (master_we_o) begin
                    for (int b = 0; b < 4; b++)
                        if (master_sel_o[b]) m[b*8 +: 8] = master_dat_o[b*8 +: 8];
                    slave_mem[a] = m;
                end
            end
        end
        if (master_cyc_o) cyc_run = cyc_run + 1;
        else if (cyc_run != 0) begin
            cyc_len = cyc_run;
            cyc_run = 0;
        end
    end

    // Reply collector with 1-3 cycle random source stalls.
    always @(posedge clk_i) begin
        if (src_cyc_o && src_stb_o && !src_stall_i) begin
            rpl_q.push_back(src_dat_o);
            if (src_we_o !== 1'b1 || src_sel_o !== 2'b11 || src_adr_o !== 2'b00) bad_attr = bad_attr + 1;
        end
        if (snk_ack_o) ack_cnt = ack_cnt + 1;
        if (src_stall_left > 0) begin
            src_stall_i    <= 1'b1;
            src_stall_left = src_stall_left - 1;
        end else if (src_stall_en && $urandom_range(9, 0) == 0) begin
            src_stall_i    <= 1'b1;
            src_stall_left = $urandom_range(2, 0);
        end else begin
            src_stall_i <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_word(input logic [1:0] a, input logic [15:0] d);
        bit stalled;
        stalled = 1'b1;
        if (throttle_en)
            while ($urandom_range(9, 0) == 0) begin
                snk_stb_i = 1'b0;
                @(posedge clk_i); #1;
            end
        snk_stb_i = 1'b1;
        snk_adr_i = a;
        snk_dat_i = d;
        for (int k = 0; k < 50 && stalled; k++) begin
            @(negedge clk_i);
            stalled = snk_stall_o;
            @(posedge clk_i); #1;
        end
        check("snk_stall_bound", 64'(stalled), 64'd0);
        xfers++;
    endtask

    task automatic send_frame(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                              input logic [31:0] dat, input int pay_bytes, input bit oob);
        logic [7:0]  p[12];
        logic [15:0] w[$];
        p[0] = 8'h5A; p[1] = {3'b101, we, sel};
        p[2] = adr[31:24]; p[3] = adr[23:16]; p[4] = adr[15:8]; p[5] = adr[7:0];
        p[6] = dat[31:24]; p[7] = dat[23:16]; p[8] = dat[15:8]; p[9] = dat[7:0];
        p[10] = 8'hC3; p[11] = 8'h3C;
        w = '{16'h0A0B, 16'h0C0D, 16'h0E0F, cur_src[47:32], cur_src[31:16], cur_src[15:0], cur_et};
        for (int i = 0; i < pay_bytes; i += 2) w.push_back({p[i], p[i+1]});
        ack_cnt   = 0;
        xfers     = 0;
        snk_cyc_i = 1'b1;
        for (int i = 0; i < w.size(); i++) begin
            if (oob && i == 2) send_word(2'b10, 16'hFFFF);
            send_word(2'b00, w[i]);
        end
        snk_stb_i = 1'b0;
        @(posedge clk_i); #1;
        snk_cyc_i = 1'b0;
    endtask

    task automatic collect_reply(input string tag);
        rpl_t e;
        int   nz;
        for (int i = 0; i < 3000 && rpl_q.size() < 30; i++) begin
            @(posedge clk_i); #1;
        end
        repeat (2) @(posedge clk_i);
        #1;
        check({tag, "_len"}, 64'(rpl_q.size()), 64'd30);
        check({tag, "_src_cyc_drop"}, 64'(src_cyc_o), 64'd0);
        check({tag, "_snk_acks"}, 64'(ack_cnt), 64'(xfers));
        check({tag, "_src_attr"}, 64'(bad_attr), 64'd0);
        if (rpl_q.size() >= 30 && rpl_exp_q.size() > 0) begin
            e  = rpl_exp_q.pop_front();
            nz = 0;
            for (int i = 10; i < 30; i++) if (rpl_q[i] != 16'd0) nz++;
            check({tag, "_dst"}, 64'({rpl_q[0], rpl_q[1], rpl_q[2]}), 64'(e.dst));
            check({tag, "_src"}, 64'({rpl_q[3], rpl_q[4], rpl_q[5]}), 64'(MAC));
            check({tag, "_etype"}, 64'(rpl_q[6]), 64'(e.et));
            check({tag, "_status"}, 64'(rpl_q[7]), 64'({14'd0, e.st}));
            check({tag, "_rdata"}, 64'({rpl_q[8], rpl_q[9]}), 64'(e.rd));
            check({tag, "_pad"}, 64'(nz), 64'd0);
        end
        rpl_q.delete();
    endtask

    task automatic do_cmd(input string tag, input logic we, input logic [3:0] sel,
                          input logic [31:0] adr, input logic [31:0] dat, input bit oob,
                          input logic [1:0] exp_st, input logic [31:0] exp_rd);
        mst_t m;
        mst_exp_q.push_back({we, sel, adr, dat});
        rpl_exp_q.push_back({cur_src, cur_et, exp_st, exp_rd});
        send_frame(we, sel, adr, dat, 12, oob);
        collect_reply(tag);
        check({tag, "_mst_cnt"}, 64'(mst_obs.size()), 64'd1);
        if (mst_obs.size() > 0 && mst_exp_q.size() > 0) begin
            m = mst_exp_q.pop_front();
            check({tag, "_mst_ctl"}, 64'({mst_obs[0].we, mst_obs[0].sel}), 64'({m.we, m.sel}));
            check({tag, "_mst_adr"}, 64'(mst_obs[0].adr), 64'(m.adr));
            check({tag, "_mst_dat"}, 64'(mst_obs[0].dat), 64'(m.dat));
        end
        mst_obs.delete();
        mst_exp_q.delete();
    endtask

    initial begin
        logic [31:0] d;
        nRst_i = 1'b0; snk_cyc_i = 1'b0; snk_stb_i = 1'b0; snk_we_i = 1'b1;
        snk_dat_i = 16'd0; snk_adr_i = 2'b00; snk_sel_i = 2'b11; src_ack_i = 1'b0;
        ack_en = 1'b1; mst_stall_en = 1'b1; src_stall_en = 1'b1; throttle_en = 1'b1;
        bad_attr = 0; cyc_run = 0; cyc_len = 0; src_stall_left = 0; ack_cnt = 0; xfers = 0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_outputs", 64'({snk_ack_o, snk_stall_o, src_cyc_o, src_stb_o, master_cyc_o, master_stb_o}), 64'd0);
        check("rst_data", 64'({src_dat_o, master_adr_o}), 64'd0);
        nRst_i = 1'b1;
        @(posedge clk_i); #1;

        cur_src = 48'h021122334455; cur_et = 16'h88B5;
        do_cmd("wr5", 1'b1, 4'hF, 32'd5, 32'hDEADBEEF, 1'b1, 2'b01, 32'd0);
        exp_mem[5] = 32'hDEADBEEF;
        cur_src = 48'h026677889900; cur_et = 16'h0800;
        do_cmd("rd5", 1'b0, 4'hF, 32'd5, 32'h13572468, 1'b0, 2'b01, exp_mem[5]);

        // Eight payload bytes: too short, silently dropped.
        send_frame(1'b1, 4'hF, 32'd6, 32'h11111111, 8, 1'b0);
        repeat (100) @(posedge clk_i);
        #1;
        check("short_mst", 64'(mst_obs.size()), 64'd0);
        check("short_reply", 64'(rpl_q.size()), 64'd0);
        check("short_acks", 64'(ack_cnt), 64'(xfers));
        cur_src = 48'h02A0A1A2A3A4; cur_et = 16'h1234;
        do_cmd("after_short", 1'b0, 4'hF, 32'd5, 32'd0, 1'b0, 2'b01, exp_mem[5]);

        // Master never acks.
        ack_en = 1'b0; mst_stall_en = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        cur_src = 48'h02B0B1B2B3B4; cur_et = 16'h4321;
        do_cmd("tmo", 1'b0, 4'h3, 32'd7, 32'd0, 1'b0, 2'b10, 32'd0);
        check("tmo_cyc_len", 64'(cyc_len), 64'(TMO));
        ack_en = 1'b1; mst_stall_en = 1'b1;

        // Reset in the middle of a frame, right after an accepted word.
        snk_cyc_i = 1'b1;
        send_word(2'b00, 16'hAAAA);
        send_word(2'b00, 16'hBBBB);
        nRst_i = 1'b0;
        @(posedge clk_i); #1;
        check("rst_rx_outputs", 64'({snk_ack_o, snk_stall_o, src_cyc_o, master_cyc_o, master_stb_o}), 64'd0);
        snk_cyc_i = 1'b0; snk_stb_i = 1'b0; nRst_i = 1'b1;
        @(posedge clk_i); #1;
        cur_src = 48'h02C0C1C2C3C4; cur_et = 16'h5555;
        do_cmd("after_rst_rx", 1'b1, 4'hF, 32'd9, 32'hCAFEF00D, 1'b0, 2'b01, 32'd0);
        exp_mem[9] = 32'hCAFEF00D;

        // Reset while the reply is going out.
        send_frame(1'b1, 4'hF, 32'd200, 32'h0BADF00D, 12, 1'b0);
        for (int i = 0; i < 500 && !src_cyc_o; i++) begin
            @(posedge clk_i); #1;
        end
        repeat (3) @(posedge clk_i);
        #1;
        check("tx_active", 64'(src_cyc_o), 64'd1);
        nRst_i = 1'b0;
        @(posedge clk_i); #1;
        check("rst_tx_outputs", 64'({src_cyc_o, src_stb_o, src_we_o, src_dat_o, master_cyc_o}), 64'd0);
        nRst_i = 1'b1;
        rpl_q.delete(); mst_obs.delete();
        @(posedge clk_i); #1;
        cur_src = 48'h02D0D1D2D3D4; cur_et = 16'h6666;
        do_cmd("after_rst_tx", 1'b0, 4'hF, 32'd9, 32'd0, 1'b0, 2'b01, exp_mem[9]);

        for (int i = 0; i < 100; i++) begin
            d = $urandom;
            cur_src = {16'h0200, 32'($urandom)};
            cur_et  = 16'($urandom);
            do_cmd("rnd_wr", 1'b1, 4'hF, 32'(i), d, 1'b0, 2'b01, 32'd0);
            exp_mem[i] = d;
        end
        for (int i = 0; i < 100; i++) begin
            cur_src = {16'h0200, 32'($urandom)};
            cur_et  = 16'($urandom);
            do_cmd("rnd_rd", 1'b0, 4'hF, 32'(i), 32'($urandom), 1'b0, 2'b01, exp_mem[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
